vga_timing_gen: RTL and testbench
=================================

// Module: vga_timing_gen
// PURPOSE
// - Parametrised successor of the X-Y counter: raster scan over a full frame, blanking included.
// - Emits aligned pixel coords (x, y), active-video, hsync/vsync and line/frame strobes.
// - Sits between the pixel-clock domain and the framebuffer read / VGA output stage.
// - Defaults give 640x480@60.
// PARAMETERS
// - H_VISIBLE  640  visible pixels per line
// - H_FRONT     16  horizontal front porch (pixels)
// - H_SYNC      96  horizontal sync width (pixels)
// - H_BACK      48  horizontal back porch (pixels)
// - V_VISIBLE  480  visible lines per frame
// - V_FRONT     10  vertical front porch (lines)
// - V_SYNC       2  vertical sync width (lines)
// - V_BACK      33  vertical back porch (lines)
// - SYNC_POL     0  active level of hsync/vsync (0 = active-low)
// - Derived: H_TOTAL = sum of H_*, V_TOTAL = sum of V_*.
// - XW = $clog2(H_TOTAL), YW = $clog2(V_TOTAL).
// PORTS
// - clock        in   1   pixel clock, all state on rising edge
// - reset        in   1   asynchronous, active-high
// - enable       in   1   advance scan by one pixel this cycle
// - x            out  XW  horizontal position, 0..H_TOTAL-1
// - y            out  YW  vertical position, 0..V_TOTAL-1
// - active       out  1   1 when x < H_VISIBLE and y < V_VISIBLE
// - hsync        out  1   SYNC_POL when H_VISIBLE+H_FRONT <= x < H_VISIBLE+H_FRONT+H_SYNC
// - vsync        out  1   SYNC_POL when V_VISIBLE+V_FRONT <= y < V_VISIBLE+V_FRONT+V_SYNC
// - line_end     out  1   1-cycle strobe, x == H_TOTAL-1
// - frame_start  out  1   1-cycle strobe, x == 0 and y == 0
// BEHAVIOUR
// - Internal counters hc, vc. On each enabled edge:
//   - hc increments; at H_TOTAL-1 it wraps to 0 and vc increments.
//   - vc wraps 0 after V_TOTAL-1 when hc wraps.
// - Output register stage:
//   - Every enabled edge, all outputs load the decode of the pre-increment (hc, vc).
//   - Outputs therefore lag the counters by one cycle and are always mutually aligned.
//   - Outputs are glitch-free.
// - enable = 0:
//   - hc, vc, x, y, active, hsync, vsync hold.
//   - line_end and frame_start are forced 0; strobes fire only on enabled cycles.
// - Reset (any time, including mid-frame):
//   - hc = vc = 0; x = 0, y = 0.
//   - active = 0, line_end = 0, frame_start = 0; hsync = vsync = ~SYNC_POL.
// - First enabled edge after reset releases: outputs show (0,0), active = 1, frame_start = 1.
// - Frame period is H_TOTAL*V_TOTAL enabled cycles. frame_start recurs exactly at that period.
// - Simultaneous wraps: at (H_TOTAL-1, V_TOTAL-1) both counters return to 0 on the same edge.
// - Widths: comparisons use XW/YW-wide constants; no counter ever exceeds TOTAL-1.
// - Elaboration check: $error if any porch/sync parameter is < 1 or any visible parameter is < 1.
// STRUCTURE
// - Package vga_timing_pkg:
//   - typedef struct timing_t {visible, front, sync, back}.
//   - Constants for 640x480@60 and 800x600@60.
//   - function total(timing_t).
// - Sub-module axis_counter #(TOTAL), instantiated twice (h, v).
//   - Ports: clock, reset, inc, count, wrap.
//   - h.wrap drives v.inc.
// - Top-level holds decode logic and the output register stage.
// TESTING (bench params H: 4/1/2/1 -> H_TOTAL=8; V: 3/1/1/1 -> V_TOTAL=6; SYNC_POL=0)
// - 1. Reset, enable = 1 for 8 cycles.
//   - x = 0..7, y = 0; active = 1 for x = 0..3; hsync = 0 only at x = 5,6.
//   - line_end = 1 only at x = 7.
// - 2. Run 48 enabled cycles.
//   - y steps 0..5; vsync = 0 only while y = 4; active = 0 for y >= 3.
//   - frame_start pulses on cycle 1 and cycle 49.
// - 3. Drop enable for 4 cycles at (x = 6, y = 2).
//   - x, y, hsync hold; strobes stay 0.
//   - Resume continues at (7, 2) with line_end = 1.
// - 4. Wrap corner: at (7, 5) next enabled output is (0, 0) with frame_start = 1.
// - 5. Assert reset mid-frame at (3, 4).
//   - Outputs go to x = 0, y = 0, active = 0, hsync = vsync = 1 without waiting for clock.
//   - First enabled edge after release gives (0, 0), frame_start = 1.
// - 6. Re-instantiate with defaults and SYNC_POL = 1.
//   - 800 cycles per line, 420000 per frame_start.
//   - hsync high for x = 656..751.

Source files
------------

// File: rtl/vga_timing_pkg.sv
// Shared timing description for the VGA raster generator: one struct per
// axis (visible / front porch / sync / back porch) plus standard modes.
package vga_timing_pkg;

    typedef struct packed {
        int unsigned visible;
        int unsigned front;
        int unsigned sync;
        int unsigned back;
    } timing_t;

    // 640x480 @ 60 Hz, 25.175 MHz pixel clock
    localparam timing_t VGA_640X480_H = '{visible: 32'd640, front: 32'd16, sync: 32'd96,  back: 32'd48};
    localparam timing_t VGA_640X480_V = '{visible: 32'd480, front: 32'd10, sync: 32'd2,   back: 32'd33};

    // 800x600 @ 60 Hz, 40 MHz pixel clock
    localparam timing_t VGA_800X600_H = '{visible: 32'd800, front: 32'd40, sync: 32'd128, back: 32'd88};
    localparam timing_t VGA_800X600_V = '{visible: 32'd600, front: 32'd1,  sync: 32'd4,   back: 32'd23};

    // Full period of one axis, blanking included
    function automatic int unsigned total(input timing_t t);
        return t.visible + t.front + t.sync + t.back;
    endfunction

endpackage

// File: rtl/vga_timing_gen_axis_counter.sv
// Modulo-TOTAL position counter for one raster axis. 'wrap' is high on the
// advancing cycle in which the count returns from TOTAL-1 to 0, so it can
// directly clock the next (slower) axis.
module axis_counter #(
    parameter  int unsigned TOTAL = 32'd8,
    localparam int unsigned W     = $clog2(TOTAL)
) (
    input  logic         clock,
    input  logic         reset,
    input  logic         inc,
    output logic [W-1:0] count,
    output logic         wrap
);

    localparam logic [W-1:0] LAST = W'(TOTAL - 32'd1);

    logic [W-1:0] count_r;

    assign count = count_r;
    assign wrap  = inc && (count_r == LAST);

    // Advance on inc, folding back to zero after the last position
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            count_r <= {W{1'b0}};
        end else if (wrap) begin
            count_r <= {W{1'b0}};
        end else if (inc) begin
            count_r <= count_r + W'(1'b1);
        end else begin
            count_r <= count_r;
        end
    end

endmodule

// File: rtl/vga_timing_gen.sv
// Raster timing generator: horizontal/vertical position counters, decode of
// visible area and sync windows, and one output register stage so that all
// outputs are glitch-free and mutually aligned (one cycle behind the counters).
module vga_timing_gen
    import vga_timing_pkg::*;
#(
    parameter  int unsigned H_VISIBLE = 32'd640,
    parameter  int unsigned H_FRONT   = 32'd16,
    parameter  int unsigned H_SYNC    = 32'd96,
    parameter  int unsigned H_BACK    = 32'd48,
    parameter  int unsigned V_VISIBLE = 32'd480,
    parameter  int unsigned V_FRONT   = 32'd10,
    parameter  int unsigned V_SYNC    = 32'd2,
    parameter  int unsigned V_BACK    = 32'd33,
    parameter  logic        SYNC_POL  = 1'b0,
    localparam int unsigned XW = $clog2(H_VISIBLE + H_FRONT + H_SYNC + H_BACK),
    localparam int unsigned YW = $clog2(V_VISIBLE + V_FRONT + V_SYNC + V_BACK)
) (
    input  logic          clock,
    input  logic          reset,
    input  logic          enable,
    output logic [XW-1:0] x,
    output logic [YW-1:0] y,
    output logic          active,
    output logic          hsync,
    output logic          vsync,
    output logic          line_end,
    output logic          frame_start
);

    localparam timing_t     H_TIM   = '{visible: H_VISIBLE, front: H_FRONT, sync: H_SYNC, back: H_BACK};
    localparam timing_t     V_TIM   = '{visible: V_VISIBLE, front: V_FRONT, sync: V_SYNC, back: V_BACK};
    localparam int unsigned H_TOTAL = total(H_TIM);
    localparam int unsigned V_TOTAL = total(V_TIM);

    // Axis boundaries at counter width
    localparam logic [XW-1:0] H_VIS_C  = XW'(H_VISIBLE);
    localparam logic [XW-1:0] H_SS_C   = XW'(H_VISIBLE + H_FRONT);
    localparam logic [XW-1:0] H_SE_C   = XW'(H_VISIBLE + H_FRONT + H_SYNC);
    localparam logic [XW-1:0] H_LAST_C = XW'(H_TOTAL - 32'd1);
    localparam logic [YW-1:0] V_VIS_C  = YW'(V_VISIBLE);
    localparam logic [YW-1:0] V_SS_C   = YW'(V_VISIBLE + V_FRONT);
    localparam logic [YW-1:0] V_SE_C   = YW'(V_VISIBLE + V_FRONT + V_SYNC);

    if (H_VISIBLE < 32'd1 || H_FRONT < 32'd1 || H_SYNC < 32'd1 || H_BACK < 32'd1 ||
        V_VISIBLE < 32'd1 || V_FRONT < 32'd1 || V_SYNC < 32'd1 || V_BACK < 32'd1) begin : g_param_check
        $error("vga_timing_gen: visible, porch and sync lengths must all be at least 1");
    end

    logic [XW-1:0] hc_s;
    logic [YW-1:0] vc_s;
    logic          h_wrap_s;
    logic          frame_wrap_unused_s;

    logic active_s;
    logic hsync_s;
    logic vsync_s;
    logic line_end_s;
    logic frame_start_s;

    axis_counter #(.TOTAL(H_TOTAL)) u_h (
        .clock (clock),
        .reset (reset),
        .inc   (enable),
        .count (hc_s),
        .wrap  (h_wrap_s)
    );

    axis_counter #(.TOTAL(V_TOTAL)) u_v (
        .clock (clock),
        .reset (reset),
        .inc   (h_wrap_s),
        .count (vc_s),
        .wrap  (frame_wrap_unused_s)
    );

    // Decode the current (pre-increment) counter position
    always_comb begin
        active_s      = 1'b0;
        hsync_s       = ~SYNC_POL;
        vsync_s       = ~SYNC_POL;
        line_end_s    = 1'b0;
        frame_start_s = 1'b0;

        active_s      = (hc_s < H_VIS_C) && (vc_s < V_VIS_C);
        hsync_s       = ((hc_s >= H_SS_C) && (hc_s < H_SE_C)) ? SYNC_POL : ~SYNC_POL;
        vsync_s       = ((vc_s >= V_SS_C) && (vc_s < V_SE_C)) ? SYNC_POL : ~SYNC_POL;
        line_end_s    = (hc_s == H_LAST_C);
        frame_start_s = (hc_s == {XW{1'b0}}) && (vc_s == {YW{1'b0}});
    end

    // Output stage: load the decode on enabled cycles, hold otherwise, strobes only when enabled
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            x           <= {XW{1'b0}};
            y           <= {YW{1'b0}};
            active      <= 1'b0;
            hsync       <= ~SYNC_POL;
            vsync       <= ~SYNC_POL;
            line_end    <= 1'b0;
            frame_start <= 1'b0;
        end else if (enable) begin
            x           <= hc_s;
            y           <= vc_s;
            active      <= active_s;
            hsync       <= hsync_s;
            vsync       <= vsync_s;
            line_end    <= line_end_s;
            frame_start <= frame_start_s;
        end else begin
            x           <= x;
            y           <= y;
            active      <= active;
            hsync       <= hsync;
            vsync       <= vsync;
            line_end    <= 1'b0;
            frame_start <= 1'b0;
        end
    end

endmodule

// File: tb/tb_vga_timing_gen.sv
// Directed bench for vga_timing_gen: a tiny 8x6 raster driven from a vector
// table, hand sequences for async reset, and a default-mode instance with
// positive sync polarity.
module tb_vga_timing_gen;

    logic clock = 1'b0;
    always #5 clock = ~clock;

    // Small instance: H 4/1/2/1 (8), V 3/1/1/1 (6), active-low sync
    logic       reset, enable;
    logic [2:0] x, y;
    logic       active, hsync, vsync, line_end, frame_start;

    vga_timing_gen #(
        .H_VISIBLE(32'd4), .H_FRONT(32'd1), .H_SYNC(32'd2), .H_BACK(32'd1),
        .V_VISIBLE(32'd3), .V_FRONT(32'd1), .V_SYNC(32'd1), .V_BACK(32'd1),
        .SYNC_POL(1'b0)
    ) dut (
        .clock(clock), .reset(reset), .enable(enable),
        .x(x), .y(y), .active(active), .hsync(hsync), .vsync(vsync),
        .line_end(line_end), .frame_start(frame_start)
    );

    // Default 640x480 instance, active-high sync
    logic       reset2, enable2;
    logic [9:0] x2, y2;
    logic       active2, hsync2, vsync2, line_end2, frame_start2;

    vga_timing_gen #(.SYNC_POL(1'b1)) dut2 (
        .clock(clock), .reset(reset2), .enable(enable2),
        .x(x2), .y(y2), .active(active2), .hsync(hsync2), .vsync(vsync2),
        .line_end(line_end2), .frame_start(frame_start2)
    );

    int total_n = 0;
    int bad_n   = 0;

    // Packed expectation: {x[2:0], y[2:0], active, hsync, vsync, line_end, frame_start}
    typedef struct packed {
        logic        en;
        logic [10:0] exp;
    } vec_t;

    vec_t tbl [0:127];
    int   n_vec;
    int   k_mod;

    localparam logic [10:0] RST_EXP = {3'd0, 3'd0, 1'b0, 1'b1, 1'b1, 1'b0, 1'b0};

    // Expected outputs for the k-th enabled cycle since reset on the 8x6 raster
    function automatic logic [10:0] model(input int k);
        int m, xi, yi;
        m  = k % 48;
        xi = m % 8;
        yi = m / 8;
        return {3'(xi), 3'(yi), (xi < 4 && yi < 3), !(xi == 5 || xi == 6),
                (yi != 4), (xi == 7), (m == 0)};
    endfunction

    task automatic add_vec(input logic en);
        tbl[n_vec].en = en;
        if (en) begin
            tbl[n_vec].exp = model(k_mod);
            k_mod++;
        end else begin
            tbl[n_vec].exp = model(k_mod - 1) & 11'b111_111_111_00;
        end
        n_vec++;
    endtask

    task automatic check(input string name, input logic [10:0] exp);
        logic [10:0] got;
        got = {x, y, active, hsync, vsync, line_end, frame_start};
        total_n++;
        if (got !== exp) begin
            bad_n++;
            $display("FAIL %s: got x=%0d y=%0d act/hs/vs/le/fs=%b required x=%0d y=%0d act/hs/vs/le/fs=%b",
                     name, got[10:8], got[7:5], got[4:0], exp[10:8], exp[7:5], exp[4:0]);
        end
    endtask

    task automatic check_int(input string name, input int got, input int exp);
        total_n++;
        if (got != exp) begin
            bad_n++;
            $display("FAIL %s: got %0d required %0d", name, got, exp);
        end
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        int kk;
        int first_le, second_le, hs_cnt;
        logic [24:0] got2, exp2;

        // Vectors: 71 enabled cycles reach (6,2) of frame 2, 4 stalled cycles,
        // then 26 enabled cycles running through the (7,5)->(0,0) frame wrap.
        n_vec = 0;
        k_mod = 0;
        for (int i = 0; i < 71; i++) add_vec(1'b1);
        for (int i = 0; i < 4; i++)  add_vec(1'b0);
        for (int i = 0; i < 26; i++) add_vec(1'b1);
        kk = k_mod;

        reset   = 1'b1;
        enable  = 1'b0;
        reset2  = 1'b1;
        enable2 = 1'b0;
        repeat (2) @(posedge clock);
        #1;
        check("reset_state", RST_EXP);
        reset = 1'b0;

        for (int i = 0; i < n_vec; i++) begin
            enable = tbl[i].en;
            @(posedge clock);
            #1;
            check($sformatf("vec%0d", i), tbl[i].exp);
        end

        // Walk on to (3,4) of frame 3, then reset between clock edges
        enable = 1'b1;
        for (int i = 0; i < 35; i++) begin
            @(posedge clock);
            #1;
            check($sformatf("run%0d", kk), model(kk));
            kk++;
        end
        #3;
        reset = 1'b1;
        #1;
        check("async_reset_midframe", RST_EXP);
        @(posedge clock);
        #1;
        check("reset_held", RST_EXP);
        reset = 1'b0;
        @(posedge clock);
        #1;
        check("first_after_reset", model(0));
        @(posedge clock);
        #1;
        check("second_after_reset", model(1));
        enable = 1'b0;

        // Default mode, positive sync: two full lines plus one pixel
        reset2    = 1'b0;
        enable2   = 1'b1;
        first_le  = -1;
        second_le = -1;
        hs_cnt    = 0;
        for (int i = 0; i < 1601; i++) begin
            int ex, ey;
            @(posedge clock);
            #1;
            ex   = i % 800;
            ey   = i / 800;
            exp2 = {10'(ex), 10'(ey), (ex < 640 && ey < 480), (ex >= 656 && ex < 752),
                    1'b0, (ex == 799), (i == 0)};
            got2 = {x2, y2, active2, hsync2, vsync2, line_end2, frame_start2};
            total_n++;
            if (got2 !== exp2) begin
                bad_n++;
                $display("FAIL dflt_cycle%0d: got x=%0d y=%0d act/hs/vs/le/fs=%b required x=%0d y=%0d act/hs/vs/le/fs=%b",
                         i, got2[24:15], got2[14:5], got2[4:0], exp2[24:15], exp2[14:5], exp2[4:0]);
            end
            if (i < 800 && hsync2) hs_cnt++;
            if (line_end2) begin
                if (first_le < 0) first_le = i;
                else if (second_le < 0) second_le = i;
            end
        end
        enable2 = 1'b0;
        check_int("dflt_line_period", second_le - first_le, 800);
        check_int("dflt_hsync_width", hs_cnt, 96);

        $display("test done: total=%0d bad=%0d", total_n, bad_n);
        $finish;
    end

endmodule
